duty_ramp: RTL and testbench

DUTY_RAMP -- requirements
Module: duty_ramp

---
 rtl/duty_ramp.sv | 122 ++++++++++++
 tb/tb_duty_ramp.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - rate-limited duty ramp in front of an 8-bit PWM value input (optional DUTY_RAMP_BYPASS_EN)
module duty_ramp #(
    parameter int STEP_DIV = 256,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target,
    input  logic       load,
    output logic [7:0] value,
    output logic       busy,
    output logic       done
);

`ifdef DUTY_RAMP_BYPASS_EN

    // Bypass: value jumps straight to the requested duty; done marks every accepted load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 8'd0;
            done  <= 1'b0;
        end else begin
            done <= load;
            if (load) begin
                value <= target;
            end
        end
    end

    assign busy = 1'b0;

`else

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    // Prescaler width covers 0..STEP_DIV-1; a divide-by-2 still needs one bit.
    localparam int            PW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(STEP_DIV - 1);
    localparam logic [8:0]    STEP9    = 9'(STEP);

    state_t        state, state_nx;
    logic [7:0]    tgt, tgt_nx;
    logic [7:0]    value_nx;
    logic [PW-1:0] presc, presc_nx;
    logic          busy_nx;
    logic          done_nx;
    logic [8:0]    gap;
    logic [8:0]    inc;
    logic [8:0]    stepped;

    // State and output registers; reset wins over everything, including a pending load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt   <= 8'd0;
            value <= 8'd0;
            presc <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            tgt   <= tgt_nx;
            value <= value_nx;
            presc <= presc_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next-state logic: a load always redirects (and suppresses a coincident step);
    // otherwise the ramp states advance value by a clamped step at prescaler terminal count.
    always_comb begin
        state_nx = state;
        tgt_nx   = tgt;
        value_nx = value;
        presc_nx = presc;
        busy_nx  = busy;
        done_nx  = 1'b0;

        // Distance to target in the current direction, 9 bits so the clamp never wraps.
        gap     = (state == RAMP_DOWN) ? ({1'b0, value} - {1'b0, tgt})
                                       : ({1'b0, tgt} - {1'b0, value});
        inc     = (gap < STEP9) ? gap : STEP9;
        stepped = (state == RAMP_DOWN) ? ({1'b0, value} - inc)
                                       : ({1'b0, value} + inc);

        if (load) begin
            tgt_nx   = target;
            presc_nx = '0;
            if (target > value) begin
                state_nx = RAMP_UP;
                busy_nx  = 1'b1;
            end else if (target < value) begin
                state_nx = RAMP_DOWN;
                busy_nx  = 1'b1;
            end else begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
            end
        end else if (state != IDLE) begin
            if (presc == PRESC_TC) begin
                presc_nx = '0;
                value_nx = stepped[7:0];
                if (stepped == {1'b0, tgt}) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end else begin
                presc_nx = presc + PW'(1);
            end
        end
    end

`endif

endmodule

// File: tb/tb_duty_ramp.sv
// tb/tb_duty_ramp.sv - self-checking bench for duty_ramp (STEP_DIV=4, STEP=1 and STEP=7 instances)
module tb_duty_ramp;

    localparam int SDIV = 4;
    localparam int S0   = 1;
    localparam int S1   = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target = 8'd0;
    logic       load = 1'b0;
    logic [7:0] dv [2];
    logic       db [2];
    logic       dd [2];

    int checks = 0;
    int errors = 0;

    // Reference: value walks toward the latched target by at most STEP every SDIV cycles
    // counted from the last load or step; busy is simply value != target.
    logic [7:0] m_val [2];
    logic [7:0] m_tgt [2];
    logic       m_done [2];
    int         m_cnt [2];

    duty_ramp #(.STEP_DIV(SDIV), .STEP(S0)) u_s1 (
        .clk(clk), .rst_n(rst_n), .target(target), .load(load),
        .value(dv[0]), .busy(db[0]), .done(dd[0])
    );

    duty_ramp #(.STEP_DIV(SDIV), .STEP(S1)) u_s7 (
        .clk(clk), .rst_n(rst_n), .target(target), .load(load),
        .value(dv[1]), .busy(db[1]), .done(dd[1])
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int d;
        int mag;
        int stp;
        for (int i = 0; i < 2; i++) begin
            stp = (i == 0) ? S0 : S1;
            if (!rst_n) begin
                m_val[i] = 8'd0; m_tgt[i] = 8'd0; m_done[i] = 1'b0; m_cnt[i] = 0;
            end else if (load) begin
                m_tgt[i]  = target;
                m_cnt[i]  = 0;
                m_done[i] = (target == m_val[i]);
`ifdef DUTY_RAMP_BYPASS_EN
                m_val[i]  = target;
                m_done[i] = 1'b1;
`endif
            end else if (m_val[i] != m_tgt[i]) begin
                m_done[i] = 1'b0;
                m_cnt[i]  = m_cnt[i] + 1;
                if (m_cnt[i] == SDIV) begin
                    m_cnt[i] = 0;
                    d   = int'(m_tgt[i]) - int'(m_val[i]);
                    mag = (d > 0) ? d : -d;
                    if (mag > stp) mag = stp;
                    m_val[i]  = 8'(int'(m_val[i]) + ((d > 0) ? mag : -mag));
                    m_done[i] = (m_val[i] == m_tgt[i]);
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic ld, input logic [7:0] t);
        load   = ld;
        target = t;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((db[0] || db[1]) && n < budget) begin
            cyc(1'b0, 8'($urandom_range(255)));
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'($urandom_range(1, 255)));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dv[i], db[i], dd[i]} !== {8'd0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL reset inst%0d: value/busy/done %0d/%0b/%0b, required 0/0/0", i, dv[i], db[i], dd[i]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

`ifndef DUTY_RAMP_BYPASS_EN
    task automatic test_ramp_up();
        logic [7:0] ev;
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        for (int e = 0; e < 16; e++) begin
            cyc(e == 0, (e == 0) ? 8'd3 : 8'($urandom_range(255)));
            ev = (e >= 12) ? 8'd3 : 8'(e / 4);
            checks++;
            if ({dv[0], db[0], dd[0]} !== {ev, e < 12, e == 12}) begin
                errors++;
                $display("FAIL ramp_up edge %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", e, dv[0], db[0], dd[0], ev, e < 12, e == 12);
            end
            checks++;
            if ({dv[1], db[1], dd[1]} !== {m_val[1], m_val[1] != m_tgt[1], m_done[1]}) begin
                errors++;
                $display("FAIL ramp_up_s7 edge %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", e, dv[1], db[1], dd[1], m_val[1], m_val[1] != m_tgt[1], m_done[1]);
            end
        end
    endtask

    task automatic test_ramp_down();
        logic [7:0] ev;
        for (int e = 0; e < 16; e++) begin
            cyc(e == 0, 8'd0);
            ev = 8'd3 - ((e / 4 > 3) ? 8'd3 : 8'(e / 4));
            checks++;
            if ({dv[0], db[0], dd[0]} !== {ev, e < 12, e == 12}) begin
                errors++;
                $display("FAIL ramp_down edge %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", e, dv[0], db[0], dd[0], ev, e < 12, e == 12);
            end
        end
    endtask

    task automatic test_big_step();
        int ev;
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        for (int e = 0; e < 24; e++) begin
            cyc(e == 0, 8'd30);
            ev = 7 * (e / 4);
            if (ev > 30) ev = 30;
            checks++;
            if ({dv[1], db[1], dd[1]} !== {8'(ev), e < 20, e == 20}) begin
                errors++;
                $display("FAIL big_step edge %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", e, dv[1], db[1], dd[1], ev, e < 20, e == 20);
            end
        end
        cyc(1'b1, 8'd250);
        wait_idle(2000);
        for (int e = 0; e < 8; e++) begin
            cyc(e == 0, 8'd255);
            ev = (e >= 4) ? 255 : 250;
            checks++;
            if ({dv[1], dd[1]} !== {8'(ev), e == 4}) begin
                errors++;
                $display("FAIL top_clamp edge %0d: value/done %0d/%0b, required %0d/%0b", e, dv[1], dd[1], ev, e == 4);
            end
            checks++;
            if ({dv[0], db[0], dd[0]} !== {m_val[0], m_val[0] != m_tgt[0], m_done[0]}) begin
                errors++;
                $display("FAIL top_clamp_s1 edge %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", e, dv[0], db[0], dd[0], m_val[0], m_val[0] != m_tgt[0], m_done[0]);
            end
        end
    endtask

    task automatic test_redirect();
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        cyc(1'b1, 8'd30);
        for (int e = 1; e < 60; e++) cyc(1'b0, 8'd0);
        // Edge 60 would step 14->15; the load must win.
        cyc(1'b1, 8'd10);
        checks++;
        if ({dv[0], db[0], dd[0]} !== {8'd14, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL redirect_load: value/busy/done %0d/%0b/%0b, required 14/1/0", dv[0], db[0], dd[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 8'd200);
            checks++;
            if (dv[0] !== ((k == 4) ? 8'd13 : 8'd14)) begin
                errors++;
                $display("FAIL redirect_step +%0d: value %0d, required %0d", k, dv[0], (k == 4) ? 13 : 14);
            end
            checks++;
            if ({dv[1], db[1], dd[1]} !== {m_val[1], m_val[1] != m_tgt[1], m_done[1]}) begin
                errors++;
                $display("FAIL redirect_s7 +%0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", k, dv[1], db[1], dd[1], m_val[1], m_val[1] != m_tgt[1], m_done[1]);
            end
        end
        wait_idle(200);
        cyc(1'b1, 8'd10);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dv[i], db[i], dd[i]} !== {8'd10, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL equal_load inst%0d: value/busy/done %0d/%0b/%0b, required 10/0/1", i, dv[i], db[i], dd[i]);
            end
        end
        cyc(1'b0, 8'd10);
        checks++;
        if ({dd[0], dd[1], db[0], db[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL equal_load_after: done0/done1/busy0/busy1 %b, required 0000", {dd[0], dd[1], db[0], db[1]});
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        cyc(1'b1, 8'd30);
        for (int e = 1; e <= 10; e++) cyc(1'b0, 8'd30);
        checks++;
        if ({dv[1], db[1]} !== {8'd14, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_pre: value/busy %0d/%0b, required 14/1", dv[1], db[1]);
        end
        rst_n = 1'b0;
        cyc(1'b1, 8'd99);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dv[i], db[i], dd[i]} !== {8'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid inst%0d: value/busy/done %0d/%0b/%0b, required 0/0/0", i, dv[i], db[i], dd[i]);
            end
        end
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 8'($urandom_range(255)));
            checks++;
            if ({dv[0], db[0], dd[0], dv[1], db[1], dd[1]} !== 20'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: v0/b0/d0 %0d/%0b/%0b v1/b1/d1 %0d/%0b/%0b, required all 0", k, dv[0], db[0], dd[0], dv[1], db[1], dd[1]);
            end
        end
    endtask
`else
    task automatic test_bypass();
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        cyc(1'b1, 8'd15);
        checks++;
        if ({dv[0], db[0], dd[0]} !== {8'd15, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bypass_load: value/busy/done %0d/%0b/%0b, required 15/0/1", dv[0], db[0], dd[0]);
        end
        cyc(1'b0, 8'd77);
        checks++;
        if ({dv[0], db[0], dd[0]} !== {8'd15, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bypass_after: value/busy/done %0d/%0b/%0b, required 15/0/0", dv[0], db[0], dd[0]);
        end
        cyc(1'b1, 8'd15);
        checks++;
        if ({dv[0], db[0], dd[0]} !== {8'd15, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bypass_equal: value/busy/done %0d/%0b/%0b, required 15/0/1", dv[0], db[0], dd[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] t;
        rst_n = 1'b0; cyc(1'b0, 8'd0); rst_n = 1'b1;
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(249) != 0);
            t = ($urandom_range(3) == 0) ? m_val[0] : 8'($urandom_range(255));
            cyc($urandom_range(19) == 0, t);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({dv[i], db[i], dd[i]} !== {m_val[i], m_val[i] != m_tgt[i], m_done[i]}) begin
                    errors++;
                    $display("FAIL random inst%0d cyc %0d: value/busy/done %0d/%0b/%0b, required %0d/%0b/%0b", i, k, dv[i], db[i], dd[i], m_val[i], m_val[i] != m_tgt[i], m_done[i]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
`ifndef DUTY_RAMP_BYPASS_EN
        test_ramp_up();
        test_ramp_down();
        test_big_step();
        test_redirect();
        test_reset_mid();
`else
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
